// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
//   Bundles the pipeline-side signals of the hazard/forwarding controller.
//   master : pipeline datapath (drives the register addresses and control bits,
//            consumes the stall/flush/forward selects)
//   slave  : pipeline_hazard_ctrl
//   Inputs to the controller : id_rs1/2, id_uses_rs1/2, id_is_branch,
//     branch_taken, ex_rd, ex_regwrite, ex_memread, ex_is_mc, mem_rd,
//     mem_regwrite, mem_memread, wb_rd, wb_regwrite
//   Outputs of the controller: pc_stall, if_id_stall, if_id_flush,
//     id_ex_bubble, ex_hold, fwd_a/b, fwd_br_a/b, mc_start, mc_busy
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] id_rs1, id_rs2;
  logic                  id_uses_rs1, id_uses_rs2;
  logic                  id_is_branch, branch_taken;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_regwrite, ex_memread, ex_is_mc;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_regwrite, mem_memread;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_regwrite;

  logic                  pc_stall, if_id_stall, if_id_flush;
  logic                  id_ex_bubble, ex_hold;
  logic [1:0]            fwd_a, fwd_b;
  logic                  fwd_br_a, fwd_br_b;
  logic                  mc_start, mc_busy;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_branch, branch_taken,
           ex_rd, ex_regwrite, ex_memread, ex_is_mc,
           mem_rd, mem_regwrite, mem_memread, wb_rd, wb_regwrite,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold,
           fwd_a, fwd_b, fwd_br_a, fwd_br_b, mc_start, mc_busy
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_branch, branch_taken,
           ex_rd, ex_regwrite, ex_memread, ex_is_mc,
           mem_rd, mem_regwrite, mem_memread, wb_rd, wb_regwrite,
    output pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold,
           fwd_a, fwd_b, fwd_br_a, fwd_br_b, mc_start, mc_busy
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard detection, ALU/branch operand forwarding and multi-cycle EX-op
//   sequencing for a 5-stage IF/ID/EX/MEM/WB pipeline with branches
//   resolved in ID.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     hz       : pipeline_hazard_ctrl_if.slave (all pipeline signals)
//     perf_stall_cycles, perf_flushes, perf_mc_ops : saturating CNT_W
//       counters, present only when HAZARD_PERF_EN is defined
//   Macro: HAZARD_PERF_EN enables the performance counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]      perf_stall_cycles,
  output logic [CNT_W-1:0]      perf_flushes,
  output logic [CNT_W-1:0]      perf_mc_ops
`endif
);

  if (MC_LATENCY < 2 || MC_LATENCY > 255 || CNT_W < 1) begin : g_bad_param
    $error("pipeline_hazard_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mc_state_t;

  // x0 is hardwired zero: never a hazard source, never forwarded
  function automatic logic match(input logic [REG_ADDR_W-1:0] x,
                                 input logic [REG_ADDR_W-1:0] y);
    return (x == y) && (y != '0);
  endfunction

  function automatic logic [1:0] alu_fwd(input logic [REG_ADDR_W-1:0] rs,
                                         input logic mem_we,
                                         input logic [REG_ADDR_W-1:0] mem_rd,
                                         input logic wb_we,
                                         input logic [REG_ADDR_W-1:0] wb_rd);
    if (mem_we && match(rs, mem_rd)) return 2'b10;
    if (wb_we && match(rs, wb_rd))   return 2'b01;
    return 2'b00;
  endfunction

  mc_state_t             state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  start_c, hold_c, busy_c;
  logic                  load_use_c, br_haz_c, hazard_c;
  logic [REG_ADDR_W-1:0] ex_rs1_p1, ex_rs2_p1;

  logic                  pc_stall_c, bubble_c, flush_c;
  logic [1:0]            fwd_a_c, fwd_b_c;
  logic                  fwd_br_a_c, fwd_br_b_c;
  logic                  ex_hold_o, mc_start_o, mc_busy_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Start cycle plus MC_LATENCY-1 BUSY cycles gives MC_LATENCY hold cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_c = 1'b0;
    hold_c  = 1'b0;
    busy_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hz.ex_is_mc) begin
          start_c = 1'b1;
          hold_c  = 1'b1;
          cnt_d   = 8'(MC_LATENCY - 2);
          state_d = BUSY;
        end
      end
      BUSY: begin
        hold_c = 1'b1;
        busy_c = 1'b1;
        if (cnt_q == 8'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign load_use_c = hz.ex_memread &&
                      ((hz.id_uses_rs1 && match(hz.id_rs1, hz.ex_rd)) ||
                       (hz.id_uses_rs2 && match(hz.id_rs2, hz.ex_rd)));

  // A branch compares in ID, so any result not yet in EX/MEM (or a load
  // still in MEM) must be waited for
  assign br_haz_c = hz.id_is_branch &&
                    ((hz.id_uses_rs1 &&
                      ((hz.ex_regwrite && match(hz.id_rs1, hz.ex_rd)) ||
                       (hz.mem_memread && match(hz.id_rs1, hz.mem_rd)))) ||
                     (hz.id_uses_rs2 &&
                      ((hz.ex_regwrite && match(hz.id_rs2, hz.ex_rd)) ||
                       (hz.mem_memread && match(hz.id_rs2, hz.mem_rd)))));

  assign hazard_c = load_use_c || br_haz_c;

  // ID -> EX boundary: source addresses follow the instruction into EX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rs1_p1 <= '0;
      ex_rs2_p1 <= '0;
    end else if (!hold_c) begin
      if (hazard_c) begin
        ex_rs1_p1 <= '0;
        ex_rs2_p1 <= '0;
      end else begin
        ex_rs1_p1 <= hz.id_rs1;
        ex_rs2_p1 <= hz.id_rs2;
      end
    end
  end

  always_comb begin
    pc_stall_c = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;
    fwd_a_c    = 2'b00;
    fwd_b_c    = 2'b00;
    fwd_br_a_c = 1'b0;
    fwd_br_b_c = 1'b0;
    ex_hold_o  = 1'b0;
    mc_start_o = 1'b0;
    mc_busy_o  = 1'b0;
    if (!rst) begin
      fwd_a_c    = alu_fwd(ex_rs1_p1, hz.mem_regwrite, hz.mem_rd, hz.wb_regwrite, hz.wb_rd);
      fwd_b_c    = alu_fwd(ex_rs2_p1, hz.mem_regwrite, hz.mem_rd, hz.wb_regwrite, hz.wb_rd);
      fwd_br_a_c = hz.id_is_branch && hz.mem_regwrite && !hz.mem_memread &&
                   match(hz.id_rs1, hz.mem_rd);
      fwd_br_b_c = hz.id_is_branch && hz.mem_regwrite && !hz.mem_memread &&
                   match(hz.id_rs2, hz.mem_rd);
      ex_hold_o  = hold_c;
      mc_start_o = start_c;
      mc_busy_o  = busy_c;
      // A held EX keeps the instruction in ID/EX, so no bubble there; a
      // pending hazard suppresses the flush until the branch operands resolve
      if (hold_c) begin
        pc_stall_c = 1'b1;
      end else if (hazard_c) begin
        pc_stall_c = 1'b1;
        bubble_c   = 1'b1;
      end else if (hz.branch_taken) begin
        flush_c = 1'b1;
      end
    end
  end

  assign hz.pc_stall     = pc_stall_c;
  assign hz.if_id_stall  = pc_stall_c;
  assign hz.id_ex_bubble = bubble_c;
  assign hz.if_id_flush  = flush_c;
  assign hz.ex_hold      = ex_hold_o;
  assign hz.fwd_a        = fwd_a_c;
  assign hz.fwd_b        = fwd_b_c;
  assign hz.fwd_br_a     = fwd_br_a_c;
  assign hz.fwd_br_b     = fwd_br_b_c;
  assign hz.mc_start     = mc_start_o;
  assign hz.mc_busy      = mc_busy_o;

`ifdef HAZARD_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
      perf_mc_ops       <= '0;
    end else begin
      perf_stall_cycles <= sat_inc(perf_stall_cycles, pc_stall_c);
      perf_flushes      <= sat_inc(perf_flushes, flush_c);
      perf_mc_ops       <= sat_inc(perf_mc_ops, mc_start_o);
    end
  end
`endif

endmodule
